// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM states,
// owner encodings and the full-word byte-enable pattern.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic       OWNER_I = 1'b0;
   localparam logic       OWNER_D = 1'b1;
   localparam logic [3:0] BE_WORD = 4'hF;

   // Fetches always read a whole word, so only the data side carries real byte enables.
   function automatic logic [3:0] owner_be(input logic owner, input logic [3:0] be);
      return (owner == OWNER_D) ? be : BE_WORD;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_mux2_1.sv
// Generic 2:1 multiplexer used to steer the shared memory bus fields
// between the fetch side (in0) and the data side (in1).
module mux2_1 #(
   parameter int WIDTH = 32
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and
// MEM-stage data accesses. One transaction is outstanding at a time. Data
// accesses win contested cycles until a streak limit is reached, after which
// a waiting fetch is served so the front end cannot starve.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] rdata,
   output logic        sel_d,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   arb_state_t  state;
   arb_state_t  state_next;
   logic        sel_d_next;
   logic [3:0]  streak;
   logic [3:0]  streak_next;
   logic        load_i;
   logic        load_d;

   logic [31:0] i_addr_q;
   logic [31:0] d_addr_q;
   logic [31:0] d_wdata_q;
   logic        d_we_q;
   logic [3:0]  d_be_q;

   // Arbitration in IDLE, handshake with memory in REQ/RESP, and routing of
   // grant/response strobes back to whichever side owns the port.
   always_comb begin
      state_next  = state;
      sel_d_next  = sel_d;
      streak_next = streak;
      load_i      = 1'b0;
      load_d      = 1'b0;
      mem_req     = 1'b0;
      i_gnt       = 1'b0;
      d_gnt       = 1'b0;
      i_rvalid    = 1'b0;
      d_rvalid    = 1'b0;

      case (state)
         IDLE: begin
            if (d_req && (!i_req || (streak < STREAK_MAX))) begin
               sel_d_next  = OWNER_D;
               load_d      = 1'b1;
               streak_next = i_req ? (streak + 4'd1) : 4'd0;
               state_next  = REQ;
            end else if (i_req) begin
               sel_d_next  = OWNER_I;
               load_i      = 1'b1;
               streak_next = 4'd0;
               state_next  = REQ;
            end
         end

         REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) begin
               i_gnt = (sel_d == OWNER_I);
               d_gnt = (sel_d == OWNER_D);
               if (mem_rvalid) begin
                  i_rvalid   = (sel_d == OWNER_I);
                  d_rvalid   = (sel_d == OWNER_D);
                  state_next = IDLE;
               end else begin
                  state_next = RESP;
               end
            end
         end

         RESP: begin
            if (mem_rvalid) begin
               i_rvalid   = (sel_d == OWNER_I);
               d_rvalid   = (sel_d == OWNER_D);
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM state, registered owner and contested-D streak counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sel_d  <= OWNER_I;
         streak <= 4'd0;
      end else begin
         state  <= state_next;
         sel_d  <= sel_d_next;
         streak <= streak_next;
      end
   end

   // Capture the winner's request fields at arbitration so later requester
   // changes cannot disturb the in-flight transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_addr_q  <= '0;
         d_addr_q  <= '0;
         d_wdata_q <= '0;
         d_we_q    <= 1'b0;
         d_be_q    <= '0;
      end else begin
         if (load_i) begin
            i_addr_q <= i_addr;
         end
         if (load_d) begin
            d_addr_q  <= d_addr;
            d_wdata_q <= d_wdata;
            d_we_q    <= d_we;
            d_be_q    <= d_be;
         end
      end
   end

   mux2_1 #(.WIDTH(32)) u_addr_mux (
      .sel (sel_d),
      .in0 (i_addr_q),
      .in1 (d_addr_q),
      .y   (mem_addr)
   );

   mux2_1 #(.WIDTH(32)) u_wdata_mux (
      .sel (sel_d),
      .in0 (32'h0),
      .in1 (d_wdata_q),
      .y   (mem_wdata)
   );

   assign mem_we = (sel_d == OWNER_D) && d_we_q;
   assign mem_be = owner_be(sel_d, d_be_q);
   assign rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A driver process plays both
// requesters and the memory; it predicts each arbitration outcome from the
// priority/streak rules and queues the expected bus transaction. A separate
// monitor process compares grants, bus fields and responses against that queue.
module tb_mem_port_arbiter;

   localparam int MAXS = 4;

   logic        clk;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] rdata;
   logic        sel_d;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   mem_port_arbiter #(.MAX_D_STREAK(MAXS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_gnt      (i_gnt),
      .i_rvalid   (i_rvalid),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_be       (d_be),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .rdata      (rdata),
      .sel_d      (sel_d),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;

   typedef struct {
      bit          is_d;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   txn_t iq[$];
   txn_t dq[$];
   exp_t expq[$];
   bit   grant_log[$];
   int   grant_cyc[$];

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   bit busy          = 0;
   bit model_owner_d = 0;
   int streak        = 0;

   int          gmin = 0, gmax = 0, rmin = 0, rmax = 0, spur_pct = 0;
   bit          rdata_fixed_en = 0;
   logic [31:0] rdata_fixed = 32'h0;
   bit          gnt_armed = 0;
   int          gnt_wait = 0;
   bit          resp_pending = 0;
   int          resp_wait = 0;
   bit          resp_orphan = 0;
   bit          resp_genuine = 0;

   bit i_gnt_seen = 0;
   bit d_gnt_seen = 0;
   int start_pct  = 100;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Memory model: grants after a random wait, responds after a random
   // delay (0 = same cycle as the grant), and can emit stray rvalid pulses.
   task automatic driveMemory();
      int d;
      mem_gnt      = 1'b0;
      mem_rvalid   = 1'b0;
      resp_genuine = 0;
      mem_rdata    = rdata_fixed_en ? rdata_fixed : $urandom();
      if (!rst_n) return;
      if (resp_pending) begin
         if (resp_wait == 0) begin
            mem_rvalid   = 1'b1;
            resp_genuine = !resp_orphan;
            resp_pending = 0;
            resp_orphan  = 0;
         end else begin
            resp_wait--;
         end
      end else if (mem_req) begin
         if (!gnt_armed) begin
            gnt_wait  = int'($urandom_range(gmax, gmin));
            gnt_armed = 1;
         end
         if (gnt_wait == 0) begin
            mem_gnt   = 1'b1;
            gnt_armed = 0;
            d = int'($urandom_range(rmax, rmin));
            if (d == 0) begin
               mem_rvalid   = 1'b1;
               resp_genuine = 1;
            end else begin
               resp_pending = 1;
               resp_wait    = d - 1;
            end
         end else begin
            gnt_wait--;
            if (int'($urandom_range(99, 0)) < spur_pct) mem_rvalid = 1'b1;
         end
      end else if (int'($urandom_range(99, 0)) < spur_pct) begin
         mem_rvalid = 1'b1;
      end
   endtask

   task automatic driveRequesters();
      if (i_req && i_gnt_seen) begin
         iq.delete(0);
         i_req = 1'b0;
      end
      if (!i_req && iq.size() > 0 && int'($urandom_range(99, 0)) < start_pct) begin
         i_req  = 1'b1;
         i_addr = iq[0].addr;
      end
      if (d_req && d_gnt_seen) begin
         dq.delete(0);
         d_req = 1'b0;
      end
      if (!d_req && dq.size() > 0 && int'($urandom_range(99, 0)) < start_pct) begin
         d_req   = 1'b1;
         d_addr  = dq[0].addr;
         d_we    = dq[0].we;
         d_wdata = dq[0].wdata;
         d_be    = dq[0].be;
      end
   endtask

   // One clock of stimulus: predict the arbitration taken at this edge from
   // the priority rules, then drive memory and requesters for the new cycle.
   task automatic applyStimulus();
      exp_t e;
      bit   both;
      @(posedge clk);
      if (rst_n) begin
         if (!busy && (i_req || d_req)) begin
            both = i_req && d_req;
            if (d_req && (!i_req || streak < MAXS)) begin
               e.is_d = 1; e.addr = d_addr; e.we = d_we; e.wdata = d_wdata; e.be = d_be;
               streak = both ? streak + 1 : 0;
            end else begin
               e.is_d = 0; e.addr = i_addr; e.we = 1'b0; e.wdata = 32'h0; e.be = 4'hF;
               streak = 0;
            end
            expq.push_back(e);
            model_owner_d = e.is_d;
            busy = 1;
         end
         if (resp_genuine) busy = 0;
      end
      #1;
      driveMemory();
      driveRequesters();
      cycle++;
      @(negedge clk);
      i_gnt_seen = i_gnt;
      d_gnt_seen = d_gnt;
      #1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((iq.size() > 0 || dq.size() > 0 || busy || i_req || d_req || resp_pending) && n < budget) begin
         applyStimulus();
         n++;
      end
      checkOutput("drain_timeout", 32'(n >= budget), 32'h0);
   endtask

   task automatic setMemory(input int gn, input int gx, input int rn, input int rx, input int sp);
      gmin = gn; gmax = gx; rmin = rn; rmax = rx; spur_pct = sp;
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'h0);
      checkOutput({tag, "_i_gnt"}, 32'(i_gnt), 32'h0);
      checkOutput({tag, "_d_gnt"}, 32'(d_gnt), 32'h0);
      checkOutput({tag, "_i_rvalid"}, 32'(i_rvalid), 32'h0);
      checkOutput({tag, "_d_rvalid"}, 32'(d_rvalid), 32'h0);
      checkOutput({tag, "_sel_d"}, 32'(sel_d), 32'h0);
   endtask

   // Monitor: pops the expected transaction on every memory grant and checks
   // bus fields, grant routing, response routing and data passthrough.
   initial begin
      exp_t e;
      logic [1:0] exp_rv;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            checkOutput("mem_req", 32'(mem_req), 32'(expq.size() != 0));
            if (mem_req && mem_gnt && expq.size() > 0) begin
               e = expq.pop_front();
               checkOutput("gnt_route", 32'({i_gnt, d_gnt}), e.is_d ? 32'h1 : 32'h2);
               checkOutput("sel_d", 32'(sel_d), 32'(e.is_d));
               checkOutput("mem_addr", mem_addr, e.addr);
               checkOutput("mem_we", 32'(mem_we), 32'(e.we));
               checkOutput("mem_wdata", mem_wdata, e.wdata);
               checkOutput("mem_be", 32'(mem_be), 32'(e.be));
               grant_log.push_back(e.is_d);
               grant_cyc.push_back(cycle);
            end else begin
               checkOutput("gnt_idle", 32'({i_gnt, d_gnt}), 32'h0);
            end
            exp_rv = resp_genuine ? (model_owner_d ? 2'b01 : 2'b10) : 2'b00;
            checkOutput("rvalid_route", 32'({i_rvalid, d_rvalid}), 32'(exp_rv));
            if (resp_genuine) checkOutput("rdata", rdata, mem_rdata);
         end
      end
   end

   initial begin
      #2000000;
      errors++;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      txn_t  t;
      string pat;
      int    n;
      rst_n = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      $display("[TB] reset state");
      #3;
      checkQuiet("reset");
      applyStimulus();
      applyStimulus();
      rst_n = 1'b1;
      applyStimulus();

      $display("[TB] single fetch");
      setMemory(0, 0, 2, 2, 0);
      rdata_fixed_en = 1; rdata_fixed = 32'h00500093;
      t.addr = 32'h100; t.we = 1'b0; t.wdata = '0; t.be = '0;
      iq.push_back(t);
      drain(50);
      rdata_fixed_en = 0;

      $display("[TB] store");
      setMemory(0, 1, 1, 1, 0);
      t.addr = 32'h2004; t.we = 1'b1; t.wdata = 32'hDEADBEEF; t.be = 4'b0011;
      dq.push_back(t);
      drain(50);

      $display("[TB] contested streak, zero-wait memory");
      setMemory(0, 0, 0, 0, 0);
      grant_log.delete();
      grant_cyc.delete();
      for (int k = 0; k < 3; k++) begin
         t.addr = 32'h1000 + 32'(k * 4); t.we = 1'b0; t.wdata = '0; t.be = '0;
         iq.push_back(t);
      end
      for (int k = 0; k < 10; k++) begin
         t.addr = 32'h3000 + 32'(k * 4); t.we = k[0]; t.wdata = $urandom(); t.be = 4'hF;
         dq.push_back(t);
      end
      drain(200);
      checkOutput("grant_count", 32'(grant_log.size()), 32'd13);
      pat = "DDDDIDDDDI";
      if (grant_log.size() >= 10) begin
         for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("grant_order[%0d]", k), 32'(grant_log[k]), 32'(pat[k] == "D"));
            if (k > 0) checkOutput($sformatf("txn_cycles[%0d]", k), 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd2);
         end
      end

      $display("[TB] fields frozen while grant stalls");
      setMemory(3, 3, 1, 1, 0);
      t.addr = 32'h40; t.we = 1'b0; t.wdata = 32'h0; t.be = 4'hF;
      dq.push_back(t);
      n = 0;
      while (!busy && n < 20) begin applyStimulus(); n++; end
      checkOutput("stall_setup_timeout", 32'(n >= 20), 32'h0);
      d_addr = 32'h80;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("stall_addr[%0d]", k), mem_addr, 32'h40);
         applyStimulus();
      end
      drain(50);

      $display("[TB] reset during response wait");
      setMemory(0, 0, 4, 4, 0);
      t.addr = 32'h300; t.we = 1'b0; t.wdata = '0; t.be = '0;
      iq.push_back(t);
      n = 0;
      while (!resp_pending && n < 20) begin applyStimulus(); n++; end
      checkOutput("resp_setup_timeout", 32'(n >= 20), 32'h0);
      applyStimulus();
      rst_n = 1'b0;
      busy = 0; streak = 0;
      resp_orphan = resp_pending;
      gnt_armed = 0;
      i_req = 1'b0; d_req = 1'b0;
      iq.delete(); dq.delete(); expq.delete();
      #1;
      checkQuiet("midreset");
      applyStimulus();
      applyStimulus();
      rst_n = 1'b1;
      drain(50);
      for (int k = 0; k < 3; k++) applyStimulus();
      checkOutput("post_reset_idle", 32'(mem_req), 32'h0);

      $display("[TB] randomized traffic");
      setMemory(0, 3, 0, 3, 10);
      start_pct = 70;
      for (int c = 0; c < 600; c++) begin
         if (iq.size() < 3 && $urandom_range(99, 0) < 20) begin
            t.addr = $urandom() & 32'hFFFF_FFFC; t.we = 1'b0; t.wdata = '0; t.be = '0;
            iq.push_back(t);
         end
         if (dq.size() < 3 && $urandom_range(99, 0) < 25) begin
            t.addr = $urandom(); t.we = 1'($urandom_range(1, 0));
            t.wdata = $urandom(); t.be = 4'($urandom_range(15, 1));
            dq.push_back(t);
         end
         applyStimulus();
      end
      drain(2000);
      applyStimulus();
      applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
